// File: rtl/instr_decode_reg_if.sv
// instr_decode_reg_if: fetch-side handshake and decoded execute-side bus of the decode register
interface instr_decode_reg_if #(parameter int PC_WIDTH = 16);
  logic                inValid;
  logic                inReady;
  logic [15:0]         instr;
  logic [PC_WIDTH-1:0] inPc;
  logic                flush;
  logic                outValid;
  logic                outReady;
  logic [PC_WIDTH-1:0] outPc;
  logic [3:0]          opcode;
  logic [3:0]          rDest;
  logic [3:0]          opExt;
  logic [3:0]          rSrc;
  logic [7:0]          immediate;
  logic                useImm;
  logic                signExtImm;
  logic                illegal;
  modport master (
    output inValid, instr, inPc, flush, outReady,
    input  inReady, outValid, outPc, opcode, rDest, opExt, rSrc, immediate, useImm, signExtImm, illegal
  );
  modport slave (
    input  inValid, instr, inPc, flush, outReady,
    output inReady, outValid, outPc, opcode, rDest, opExt, rSrc, immediate, useImm, signExtImm, illegal
  );
endinterface

// File: rtl/instr_decode_reg.sv
// instr_decode_reg: fetch-to-execute register with 2-entry skid buffer and immediate-form decode
module instr_decode_reg #(
  parameter int          PC_WIDTH  = 16,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input logic            clk,
  input logic            rst_n,
  instr_decode_reg_if.slave bus
);
  logic                main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [15:0]         main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic                accept, pop, main_takes_skid, main_free;
  logic [15:0]         head;
  logic                sext, zext;

  // next state: flush wins, otherwise pop before push so order is preserved
  always_comb begin
    accept          = bus.inValid && !skid_valid_q;
    pop             = main_valid_q && bus.outReady;
    main_takes_skid = pop && skid_valid_q;
    main_free       = !main_valid_q || pop;
    main_valid_d    = bus.flush ? 1'b0 : main_takes_skid ? 1'b1 : main_free ? accept : 1'b1;
    main_instr_d    = main_takes_skid ? skid_instr_q : (main_free && accept) ? bus.instr : main_instr_q;
    main_pc_d       = main_takes_skid ? skid_pc_q : (main_free && accept) ? bus.inPc : main_pc_q;
    skid_valid_d    = bus.flush ? 1'b0 : main_takes_skid ? accept : (!main_free && accept) ? 1'b1 : skid_valid_q;
    skid_instr_d    = (accept && !main_free) || (accept && main_takes_skid) ? bus.instr : skid_instr_q;
    skid_pc_d       = (accept && !main_free) || (accept && main_takes_skid) ? bus.inPc : skid_pc_q;
  end

  // entry storage, asynchronously cleared to an empty NOP state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_instr_q <= NOP_INSTR;
      skid_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      skid_pc_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_instr_q <= main_instr_d;
      skid_instr_q <= skid_instr_d;
      main_pc_q    <= main_pc_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // field split and immediate-form classification of the head entry
  always_comb begin
    head = main_valid_q ? main_instr_q : NOP_INSTR;
    sext = head[15:12] inside {4'h1, 4'h2, 4'h3, 4'h8, 4'hD};
    zext = head[15:12] inside {4'h5, 4'h6, 4'h7, 4'hF};
  end

  assign bus.inReady    = !skid_valid_q;
  assign bus.outValid   = main_valid_q;
  assign bus.outPc      = main_valid_q ? main_pc_q : '0;
  assign bus.opcode     = head[15:12];
  assign bus.rDest      = head[11:8];
  assign bus.opExt      = head[7:4];
  assign bus.rSrc       = head[3:0];
  assign bus.immediate  = head[7:0];
  assign bus.useImm     = sext || zext;
  assign bus.signExtImm = sext;
  assign bus.illegal    = !(sext || zext || head[15:12] == 4'h0);
endmodule

// File: doc/instr_decode_reg.md
Name: instr_decode_reg

Overview:
- Fetch-to-execute pipeline register with a 2-entry skid buffer.
- Registers one 16-bit instruction per valid/ready handshake and splits it into fields.
- Classifies the immediate form and produces the 8-bit immediate plus the signExtImm select consumed by the sign-extend stage.
- Sits between instruction fetch and the ALU operand path; absorbs one cycle of downstream stall without a combinational ready path from out to in.

Parameters:
- PC_WIDTH, 16, width of the program counter carried alongside each instruction.
- NOP_INSTR, 16'h0000, instruction value presented on the field outputs when no entry is valid.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- inValid  input  1  fetch presents a valid instruction
- inReady  output  1  block can accept; high when skid entry is empty
- instr  input  16  raw instruction word
- inPc  input  PC_WIDTH  address of instr
- flush  input  1  discard all held and incoming instructions (branch taken)
- outValid  output  1  head entry valid
- outReady  input  1  downstream consumes head entry this cycle
- outPc  output  PC_WIDTH  pc of head entry
- opcode  output  4  head instr[15:12]
- rDest  output  4  head instr[11:8]
- opExt  output  4  head instr[7:4]
- rSrc  output  4  head instr[3:0]
- immediate  output  8  head instr[7:0]
- useImm  output  1  head is an immediate-form instruction
- signExtImm  output  1  immediate must be sign-extended (1) or zero-extended (0)
- illegal  output  1  head opcode is unassigned

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each holding {valid, instr, pc}.
- Reset (rst_n low, asynchronous): both valid bits cleared, stored instr set to NOP_INSTR, stored pc set to 0.
- Output values while in reset: outValid=0, outPc=0, all field outputs decoded from NOP_INSTR, inReady=1.
- inReady = !skidValid; registered state only, with no combinational path from outReady.
- Accept: inValid && inReady at a rising edge. Pop: outValid && outReady at a rising edge.
- Latency: instruction accepted at edge N is on the outputs after edge N when the main entry is empty or popping at N.
- Next-state rules per edge (flush low):
  - Pop only: skid moves to main when skid valid; otherwise main is cleared.
  - Accept only: goes to main if main is empty, else to skid.
  - Accept and pop together: if skid valid, skid moves to main and the new instr goes to skid (cannot occur in practice, since skid valid forces inReady=0); else the new instr goes to main.
- Order is strictly preserved; no instruction is dropped or duplicated unless flushed.
- Flush has priority over all other events. At the edge: both valids cleared and the input of that same cycle is dropped even if inValid && inReady. outValid=0 and inReady=1 on the following cycle.
- Flush while empty: no effect.
- When outValid=0, field outputs show NOP_INSTR fields. Stalled outputs stay stable while outValid && !outReady.
- Decode is combinational from the main entry. Unlisted opcodes give useImm=0, signExtImm=0, illegal=1.
  - 0000 register-form: useImm=0, signExtImm=0.
  - 0001 ADDI, 0010 SUBI, 0011 CMPI, 1000 shift-imm, 1101 MOVI: useImm=1, signExtImm=1.
  - 0101 ANDI, 0110 ORI, 0111 XORI, 1111 LUI: useImm=1, signExtImm=0.
- illegal is only meaningful when outValid=1; the block does not trap.

Test Plan:
- Reset mid-stream: assert rst_n=0 with both entries full -> outValid=0 and inReady=1 immediately (asynchronous), opcode=0, outPc=0.
- Streaming: outReady held 1, send instr 16'h1A85 pc=0x10 then 16'h5A85 pc=0x12 on back-to-back cycles -> one cycle later opcode=1, rDest=A, immediate=8'h85, useImm=1, signExtImm=1. Next cycle opcode=5, signExtImm=0. Throughput is one per cycle.
- Stall/skid: outReady=0, send 16'h3104 then 16'h6207 -> after 2 edges inReady=0 and outputs hold 3104. Raise outReady -> 3104 pops, then 6207 appears, then inReady=1.
- Flush priority: two entries held plus inValid=1 with 16'h7333 and flush=1 -> next cycle outValid=0, inReady=1, and 7333 never appears.
- Decode sweep: all 16 opcodes with immediate field 8'hF0 -> useImm, signExtImm and illegal match the table (e.g. 0100 gives illegal=1), immediate=8'hF0.
- Randomized valid/ready with sequential pcs: the output pc sequence equals the input pc sequence, with no gaps or repeats.
